// File: rtl/tri_raster_scan.sv
// tri_raster_scan: clipped bounding-box raster sweep of one triangle feeding a point-in-triangle comparator
// Ports: clk/rst (sync, active high); start + Ax..Cy latch a triangle in IDLE;
//   test_req/Px/Py -> comparator, test_ack/test_inside <- comparator;
//   pix_valid/pix_x/pix_y/pix_inside -> framebuffer writer, pix_ready <- writer;
//   busy (not IDLE), done (1-cycle end pulse), inside_count (inside pixels this/last sweep).
// Option: TRI_RASTER_INSIDE_ONLY_EN emits only pixels the comparator reports as inside.
module tri_raster_scan #(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int XW    = 11,
   parameter int YW    = 10,
   parameter int CW    = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [XW-1:0] Ax,
   input  logic [XW-1:0] Bx,
   input  logic [XW-1:0] Cx,
   input  logic [YW-1:0] Ay,
   input  logic [YW-1:0] By,
   input  logic [YW-1:0] Cy,
   output logic          busy,
   output logic          done,
   output logic          test_req,
   output logic [XW-1:0] Px,
   output logic [YW-1:0] Py,
   input  logic          test_ack,
   input  logic          test_inside,
   output logic          pix_valid,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          pix_inside,
   input  logic          pix_ready,
   output logic [CW-1:0] inside_count
);
   typedef enum logic [2:0] {IDLE, BBOX, ISSUE, WAIT, EMIT, ADV, DONE} state_t;
   localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
   state_t state;
   logic [XW-1:0] ax, bx, cx, x_lo, x_hi, x_min, x_max;
   logic [YW-1:0] ay, by, cy, y_lo, y_hi, y_min, y_max;
   // Box derived from the latched vertices; they are stable for the whole sweep.
   always_comb begin
      x_lo  = ax < bx ? ax : bx;
      x_lo  = cx < x_lo ? cx : x_lo;
      x_hi  = ax > bx ? ax : bx;
      x_hi  = cx > x_hi ? cx : x_hi;
      y_lo  = ay < by ? ay : by;
      y_lo  = cy < y_lo ? cy : y_lo;
      y_hi  = ay > by ? ay : by;
      y_hi  = cy > y_hi ? cy : y_hi;
      x_min = x_lo > X_LAST ? X_LAST : x_lo;
      x_max = x_hi > X_LAST ? X_LAST : x_hi;
      y_min = y_lo > Y_LAST ? Y_LAST : y_lo;
      y_max = y_hi > Y_LAST ? Y_LAST : y_hi;
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         done         <= 1'b0;
         test_req     <= 1'b0;
         pix_valid    <= 1'b0;
         pix_inside   <= 1'b0;
         Px           <= '0;
         Py           <= '0;
         pix_x        <= '0;
         pix_y        <= '0;
         inside_count <= '0;
         ax           <= '0;
         bx           <= '0;
         cx           <= '0;
         ay           <= '0;
         by           <= '0;
         cy           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               ax           <= Ax;
               bx           <= Bx;
               cx           <= Cx;
               ay           <= Ay;
               by           <= By;
               cy           <= Cy;
               inside_count <= '0;
               state        <= BBOX;
            end
            BBOX: if (x_lo > X_LAST || y_lo > Y_LAST) begin
               done  <= 1'b1;
               state <= DONE;
            end else begin
               Px    <= x_min;
               Py    <= y_min;
               state <= ISSUE;
            end
            ISSUE: begin
               test_req <= 1'b1;
               state    <= WAIT;
            end
            WAIT: if (test_ack) begin
               test_req <= 1'b0;
`ifdef TRI_RASTER_INSIDE_ONLY_EN
               if (!test_inside) state <= ADV;
               else begin
                  pix_valid  <= 1'b1;
                  pix_x      <= Px;
                  pix_y      <= Py;
                  pix_inside <= 1'b1;
                  state      <= EMIT;
               end
`else
               pix_valid  <= 1'b1;
               pix_x      <= Px;
               pix_y      <= Py;
               pix_inside <= test_inside;
               state      <= EMIT;
`endif
            end
            EMIT: if (pix_ready) begin
               pix_valid <= 1'b0;
               if (pix_inside && inside_count != '1) inside_count <= inside_count + CW'(1);
               state <= ADV;
            end
            ADV: if (Px == x_max && Py == y_max) begin
               done  <= 1'b1;
               state <= DONE;
            end else begin
               Px    <= Px == x_max ? x_min : Px + XW'(1);
               Py    <= Px == x_max ? Py + YW'(1) : Py;
               state <= ISSUE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
